// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write arbiter that lets N producers share one FIFO write port.
// One producer owns the port at a time. It keeps ownership for up to BURST
// accepted beats. It loses ownership as soon as it drops req_valid. The FIFO
// full flag back-pressures the owner. Producers that do not own the port
// always see req_ready=0.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous, active-low reset
//   req_valid   [N]      per-requester data valid
//   req_data    [N*DW]   packed data, requester i at [i*DW +: DW]
//   req_ready   [N]      per-requester accept (transfer = valid & ready)
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write enable
//   fifo_dt_in  [DW]     FIFO write data (owner's slice)
//   grant       [N]      one-hot current owner, 0 when idle
//   grant_id    [IDW]    index of current owner, 0 when idle
//   busy        1 while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int IDW  = $clog2(N),
    localparam int CW   = $clog2(BURST) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    req_ready,
    input  logic            fifo_full,
    output logic            fifo_wr_en,
    output logic [DW-1:0]   fifo_dt_in,
    output logic [N-1:0]    grant,
    output logic [IDW-1:0]  grant_id,
    output logic            busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic [IDW-1:0]   grant_id_reg, grant_id_next;
    logic [CW-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [IDW-1:0]   last_owner_reg, last_owner_next;

    logic [DW-1:0]    req_slice [N];
    logic             owner_valid;
    logic             beat_ok;
    logic             pick_any;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   pick_base;

    // Per-requester data slices and ready. Ready is also held low while reset
    // is asserted, so nothing is accepted or written in a reset cycle even
    // though the grant register still holds its old value until the edge.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req
            assign req_slice[gi] = req_data[gi*DW +: DW];
            assign req_ready[gi] = grant_reg[gi] & ~fifo_full & rst_n;
        end
    endgenerate

    assign owner_valid = |(grant_reg & req_valid);
    assign beat_ok     = owner_valid & ~fifo_full;
    assign fifo_wr_en  = beat_ok & rst_n;
    assign fifo_dt_in  = req_slice[grant_id_reg];
    assign grant       = grant_reg;
    assign grant_id    = grant_id_reg;
    assign busy        = (state_reg == BUSY);

    // The search starts one past the previous owner. Every release records the
    // current owner as last_owner, so when BUSY the search starts from the
    // current owner. The owner itself is visited last and still wins when it is
    // the only requester asserting valid.
    assign pick_base = (state_reg == BUSY) ? grant_id_reg : last_owner_reg;

    always_comb begin
        int idx;
        idx      = 0;
        pick_any = 1'b0;
        pick_id  = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(pick_base) + k) % N;
            if (!pick_any && req_valid[idx]) begin
                pick_any = 1'b1;
                pick_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        logic release_now;
        release_now     = 1'b0;
        state_next      = state_reg;
        grant_next      = grant_reg;
        grant_id_next   = grant_id_reg;
        beat_cnt_next   = beat_cnt_reg;
        last_owner_next = last_owner_reg;

        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next          = BUSY;
                    grant_next          = '0;
                    grant_next[pick_id] = 1'b1;
                    grant_id_next       = pick_id;
                    beat_cnt_next       = '0;
                end
            end
            BUSY: begin
                if (!owner_valid) begin
                    // Owner dropped. This also covers a drop while the FIFO is full.
                    release_now = 1'b1;
                end else if (beat_ok) begin
                    if (beat_cnt_reg == CW'(BURST - 1)) begin
                        release_now = 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
                // Owner valid but the FIFO is full: stall. Grant and count hold.

                if (release_now) begin
                    last_owner_next = grant_id_reg;
                    beat_cnt_next   = '0;
                    if (pick_any) begin
                        grant_next          = '0;
                        grant_next[pick_id] = 1'b1;
                        grant_id_next       = pick_id;
                    end else begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        grant_id_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            grant_id_reg   <= '0;
            beat_cnt_reg   <= '0;
            last_owner_reg <= IDW'(N - 1);
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            grant_id_reg   <= grant_id_next;
            beat_cnt_reg   <= beat_cnt_next;
            last_owner_reg <= last_owner_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed scenario tasks plus a randomized scoreboard run for fifo_wr_arbiter
// (N=4, DW=8, BURST=4). Inputs are driven 1 ns after the rising edge. Outputs
// are sampled 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_dt_in;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(.N(N), .DW(DW), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_dt_in(fifo_dt_in),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h33221100;
        fifo_full = 1'b0;
        cyc();
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL reset_wr: got wr_en=%b ready=%b want 0/0000", fifo_wr_en, req_ready); end
        $display("[%0t] reset: grant=%b busy=%b wr_en=%b", $time, grant, busy, fifo_wr_en);
    endtask

    // Lone requester: six beats back to back, re-granted at the burst boundary.
    task automatic test_single_owner();
        do_reset();
        req_valid = 4'b0001;
        set_data(0, 8'hA0);
        #1;
        checks++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin failures++; $display("FAIL t1_idle: got grant=%b wr_en=%b want 0000/0", grant, fifo_wr_en); end
        cyc();
        for (int k = 0; k < 6; k++) begin
            set_data(0, 8'(8'hA0 + k));
            #1;
            checks++; if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL t1_grant beat%0d: got grant=%b busy=%b want 0001/1", k, grant, busy); end
            checks++; if (fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'(8'hA0 + k)) begin failures++; $display("FAIL t1_write beat%0d: got wr_en=%b data=%h want 1/%h", k, fifo_wr_en, fifo_dt_in, 8'(8'hA0 + k)); end
            $display("[%0t] t1 write req0 data=%h", $time, fifo_dt_in);
            cyc();
        end
        req_valid = 4'b0000;
        #1;
        checks++; if (fifo_wr_en !== 1'b0 || grant !== 4'b0001) begin failures++; $display("FAIL t1_drop: got wr_en=%b grant=%b want 0/0001", fifo_wr_en, grant); end
        cyc();
        #1;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin failures++; $display("FAIL t1_idle_after: got busy=%b grant=%b want 0/0000", busy, grant); end
    endtask

    // All four valid: owners 0,1,2,3,0 with four beats each and no gap.
    task automatic test_round_robin();
        int seq [N];
        int owner;
        do_reset();
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            set_data(i, {2'(i), 6'd0});
        end
        req_valid = 4'b1111;
        #1;
        checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL t2_idle: got wr_en=%b want 0", fifo_wr_en); end
        cyc();
        for (int c = 0; c < 20; c++) begin
            owner = (c / BURST) % N;
            for (int i = 0; i < N; i++) set_data(i, {2'(i), 6'(seq[i])});
            #1;
            checks++; if (grant !== 4'(1 << owner) || grant_id !== 2'(owner)) begin failures++; $display("FAIL t2_owner c%0d: got grant=%b id=%0d want %b/%0d", c, grant, grant_id, 4'(1 << owner), owner); end
            checks++; if (fifo_wr_en !== 1'b1 || fifo_dt_in !== {2'(owner), 6'(seq[owner])}) begin failures++; $display("FAIL t2_write c%0d: got wr_en=%b data=%h want 1/%h", c, fifo_wr_en, fifo_dt_in, {2'(owner), 6'(seq[owner])}); end
            $display("[%0t] t2 write req%0d data=%h", $time, owner, fifo_dt_in);
            seq[owner]++;
            cyc();
        end
        req_valid = 4'b0000;
        cyc();
    endtask

    // FIFO full for three cycles after two beats. Stalled cycles must not count.
    task automatic test_full_stall();
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'h10);
        #1;
        cyc();
        for (int k = 0; k < 2; k++) begin
            set_data(1, 8'(8'h10 + k));
            #1;
            checks++; if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'(8'h10 + k)) begin failures++; $display("FAIL t3_pre beat%0d: got grant=%b wr_en=%b data=%h want 0010/1/%h", k, grant, fifo_wr_en, fifo_dt_in, 8'(8'h10 + k)); end
            $display("[%0t] t3 write req1 data=%h", $time, fifo_dt_in);
            cyc();
        end
        fifo_full = 1'b1;
        req_valid = 4'b0110;
        set_data(1, 8'h12);
        set_data(2, 8'h20);
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || grant !== 4'b0010) begin failures++; $display("FAIL t3_stall s%0d: got wr_en=%b ready=%b grant=%b want 0/0000/0010", s, fifo_wr_en, req_ready, grant); end
            $display("[%0t] t3 stall grant=%b", $time, grant);
            cyc();
        end
        fifo_full = 1'b0;
        for (int k = 2; k < 4; k++) begin
            set_data(1, 8'(8'h10 + k));
            #1;
            checks++; if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'(8'h10 + k)) begin failures++; $display("FAIL t3_post beat%0d: got grant=%b wr_en=%b data=%h want 0010/1/%h", k, grant, fifo_wr_en, fifo_dt_in, 8'(8'h10 + k)); end
            $display("[%0t] t3 write req1 data=%h", $time, fifo_dt_in);
            cyc();
        end
        #1;
        checks++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'h20) begin failures++; $display("FAIL t3_rotate: got grant=%b wr_en=%b data=%h want 0100/1/20", grant, fifo_wr_en, fifo_dt_in); end
        $display("[%0t] t3 write req2 data=%h", $time, fifo_dt_in);
        req_valid = 4'b0000;
        cyc();
    endtask

    // Owner 0 drops valid after two beats. Requester 2 takes over next cycle.
    task automatic test_owner_drop();
        do_reset();
        req_valid = 4'b0101;
        set_data(0, 8'hB0);
        set_data(2, 8'hC0);
        #1;
        cyc();
        for (int k = 0; k < 2; k++) begin
            set_data(0, 8'(8'hB0 + k));
            #1;
            checks++; if (grant !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'(8'hB0 + k)) begin failures++; $display("FAIL t4_req0 beat%0d: got grant=%b wr_en=%b data=%h want 0001/1/%h", k, grant, fifo_wr_en, fifo_dt_in, 8'(8'hB0 + k)); end
            $display("[%0t] t4 write req0 data=%h", $time, fifo_dt_in);
            cyc();
        end
        req_valid = 4'b0100;
        #1;
        checks++; if (grant !== 4'b0001 || fifo_wr_en !== 1'b0) begin failures++; $display("FAIL t4_drop: got grant=%b wr_en=%b want 0001/0", grant, fifo_wr_en); end
        cyc();
        for (int k = 0; k < 2; k++) begin
            set_data(2, 8'(8'hC0 + k));
            #1;
            checks++; if (grant !== 4'b0100 || fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'(8'hC0 + k)) begin failures++; $display("FAIL t4_req2 beat%0d: got grant=%b wr_en=%b data=%h want 0100/1/%h", k, grant, fifo_wr_en, fifo_dt_in, 8'(8'hC0 + k)); end
            $display("[%0t] t4 write req2 data=%h", $time, fifo_dt_in);
            cyc();
        end
        req_valid = 4'b0000;
        cyc();
    endtask

    // Reset in the middle of a burst by requester 3. Requester 0 must win first afterwards.
    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b1000;
        set_data(3, 8'hD0);
        #1;
        cyc();
        for (int k = 0; k < 2; k++) begin
            set_data(3, 8'(8'hD0 + k));
            #1;
            checks++; if (grant !== 4'b1000 || fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'(8'hD0 + k)) begin failures++; $display("FAIL t5_req3 beat%0d: got grant=%b wr_en=%b data=%h want 1000/1/%h", k, grant, fifo_wr_en, fifo_dt_in, 8'(8'hD0 + k)); end
            $display("[%0t] t5 write req3 data=%h", $time, fifo_dt_in);
            cyc();
        end
        rst_n     = 1'b0;
        req_valid = 4'b1001;
        set_data(0, 8'hE0);
        #1;
        checks++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin failures++; $display("FAIL t5_in_reset: got wr_en=%b ready=%b want 0/0000", fifo_wr_en, req_ready); end
        cyc();
        rst_n = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || fifo_wr_en !== 1'b0) begin failures++; $display("FAIL t5_after_reset: got grant=%b busy=%b wr_en=%b want 0000/0/0", grant, busy, fifo_wr_en); end
        cyc();
        #1;
        checks++; if (grant !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_dt_in !== 8'hE0) begin failures++; $display("FAIL t5_first_pick: got grant=%b wr_en=%b data=%h want 0001/1/e0", grant, fifo_wr_en, fifo_dt_in); end
        $display("[%0t] t5 write req0 data=%h", $time, fifo_dt_in);
        req_valid = 4'b0000;
        cyc();
    endtask

    // Random valid/full traffic. Each data byte carries {requester id, sequence}.
    // Every write must carry the next in-order sequence of a requester that is
    // handshaking. The grant must hold across any stalled beat.
    task automatic test_scoreboard();
        int          seq [N];
        int          id;
        logic        prev_stall;
        logic [N-1:0] prev_grant;
        do_reset();
        for (int i = 0; i < N; i++) seq[i] = 0;
        prev_stall = 1'b0;
        prev_grant = '0;
        for (int c = 0; c < 500; c++) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                set_data(i, {2'(i), 6'(seq[i])});
            end
            #1;
            checks++; if ($countones(req_ready) > 1 || (fifo_full && (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0))) begin failures++; $display("FAIL t6_ready c%0d: got ready=%b wr_en=%b full=%b want onehot0 and idle when full", c, req_ready, fifo_wr_en, fifo_full); end
            if (prev_stall) begin
                checks++; if (grant !== prev_grant) begin failures++; $display("FAIL t6_stall_hold c%0d: got grant=%b want %b", c, grant, prev_grant); end
            end
            if (fifo_wr_en === 1'b1) begin
                id = int'(fifo_dt_in[7:6]);
                checks++; if (!(req_ready[id] && req_valid[id]) || fifo_dt_in !== {2'(id), 6'(seq[id])}) begin failures++; $display("FAIL t6_data c%0d: got data=%h ready=%b valid=%b want %h from an accepted req%0d", c, fifo_dt_in, req_ready, req_valid, {2'(id), 6'(seq[id])}, id); end
                $display("[%0t] t6 write req%0d data=%h", $time, id, fifo_dt_in);
                seq[id]++;
            end else begin
                checks++; if ((req_ready & req_valid) !== 4'b0000) begin failures++; $display("FAIL t6_lost c%0d: got handshake ready=%b valid=%b with wr_en=%b want no handshake", c, req_ready, req_valid, fifo_wr_en); end
            end
            prev_stall = fifo_full && ((grant & req_valid) != 4'b0000);
            prev_grant = grant;
            cyc();
        end
        req_valid = '0;
        fifo_full = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        test_reset();
        test_single_owner();
        test_round_robin();
        test_full_stall();
        test_owner_drop();
        test_reset_mid_burst();
        test_scoreboard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
